pow_arbiter: RTL and testbench

Round-robin scheduler that shares one iterative multiplier among `N_REQ` requesters, each of which needs `n` raised to a fixed power. It accepts one request at a time and raises the latched operand to `POWER` by repeated multiplication, one multiply per clock. It then returns the truncated result with a one-hot completion strobe. It sits between the pow_5 clients and the single-multiplier resource, so one multiplier is instantiated instead of one per client.

---
 rtl/pow_arbiter_pkg.sv | 15 +
 rtl/pow_arbiter_if.sv | 18 +
 rtl/pow_arbiter_rr_arbiter.sv | 30 +++
 rtl/pow_arbiter.sv | 113 +++++++++++
 tb/tb_pow_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pow_arbiter_pkg.sv
// Shared definitions for the round-robin power scheduler: state encoding and
// default geometry.
package pow_arb_pkg;

  localparam int DEFAULT_N_REQ = 4;
  localparam int DEFAULT_WIDTH = 18;
  localparam int DEFAULT_POWER = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pow_arbiter_if.sv
// Client-side bundle of the power scheduler: requests/operands in,
// grant/done strobes, result and busy out.
interface pow_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 18
) ();

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] n;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic [WIDTH-1:0]       result;
  logic                   busy;

  modport master (output req, output n, input grant, input done, input result, input busy);
  modport slave  (input req, input n, output grant, output done, output result, output busy);

endinterface

// File: rtl/pow_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// last+1 with wrap-around.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic hit_s;

  // Walk candidates in priority order; only the first hit is recorded.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    hit_s    = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      hit_s    = !any && req[(int'(last) + i) % N_REQ];
      pick     = pick | ({{(N_REQ-1){1'b0}}, hit_s} << ((int'(last) + i) % N_REQ));
      pick_idx = hit_s ? IDX_W'((int'(last) + i) % N_REQ) : pick_idx;
      any      = any | hit_s;
    end
  end

endmodule

// File: rtl/pow_arbiter.sv
// Shares one multiplier among N_REQ clients: accepts one request at a time and
// raises the latched operand to POWER, one multiply per clock.
module pow_arbiter
  import pow_arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int POWER = DEFAULT_POWER
) (
  input logic         clock,
  input logic         reset_n,
  pow_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(POWER) + 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(POWER - 2);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rn_q;
  logic [WIDTH-1:0] acc_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] last_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;

  logic [N_REQ-1:0] pick_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             any_s;
  logic [WIDTH-1:0] win_n_s;
  logic [WIDTH-1:0] prod_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req      (bus.req),
    .last     (last_q),
    .pick     (pick_s),
    .pick_idx (pick_idx_s),
    .any      (any_s)
  );

  // Operand of the current arbitration winner.
  always_comb begin
    win_n_s = bus.n[int'(pick_idx_s)*WIDTH +: WIDTH];
  end

  // Single shared multiplier, truncated to WIDTH.
  always_comb begin
    prod_s = acc_q * rn_q;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rn_q     <= '0;
      acc_q    <= '0;
      owner_q  <= '0;
      last_q   <= LAST_RST;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (any_s) begin
            rn_q    <= win_n_s;
            acc_q   <= win_n_s;
            owner_q <= pick_idx_s;
            last_q  <= pick_idx_s;
            cnt_q   <= CNT_INIT;
            grant_q <= pick_s;
            busy_q  <= 1'b1;
            state_q <= ST_MUL;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_MUL: begin
          acc_q <= prod_s;
          if (cnt_q == '0) begin
            result_q <= prod_s;
            done_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_pow_arbiter.sv
// Scoreboard bench for pow_arbiter: expected completions are queued when
// requests are driven and popped when done strobes appear.
module tb_pow_arbiter;

  localparam int NR = 4;
  localparam int W  = 18;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pow_arbiter_if #(.N_REQ(NR), .WIDTH(W)) bus ();

  pow_arbiter #(.N_REQ(NR), .WIDTH(W), .POWER(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [NR-1:0] oh;
    logic [W-1:0]  res;
  } exp_t;

  exp_t sb[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic push_exp(input int c, input logic [W-1:0] r);
    exp_t e;
    e.oh  = 4'b0001 << c;
    e.res = r;
    sb.push_back(e);
  endtask

  task automatic set_n(input int c, input logic [W-1:0] v);
    bus.n[c*W +: W] = v;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    bus.req = 4'b0000;
    bus.n   = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic wait_grant(output logic [NR-1:0] g, output int cyc);
    g = '0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      cyc++;
      if (bus.grant != 4'b0000) begin
        g = bus.grant;
        break;
      end
    end
  endtask

  task automatic wait_done(output logic [NR-1:0] d, output logic [W-1:0] r,
                           output int cyc, output bit sg);
    d = '0;
    r = '0;
    cyc = 0;
    sg = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      cyc++;
      if (bus.grant != 4'b0000) sg = 1'b1;
      if (bus.done != 4'b0000) begin
        d = bus.done;
        r = bus.result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req = 4'b0000;
    bus.n   = '0;
    do_reset();
    total_cnt++; if (bus.grant !== 4'b0000) $display("FAIL reset_grant got %b want 0000", bus.grant); else pass_cnt++;
    total_cnt++; if (bus.done !== 4'b0000) $display("FAIL reset_done got %b want 0000", bus.done); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.result !== 18'd0) $display("FAIL reset_result got %0d want 0", bus.result); else pass_cnt++;
  endtask

  task automatic test_single();
    logic [NR-1:0] g, d;
    logic [W-1:0]  r;
    int gc, dc;
    bit sg;
    exp_t e;
    set_n(1, 18'd3);
    push_exp(1, 18'd243);
    @(negedge clock);
    bus.req = 4'b0010;
    wait_grant(g, gc);
    total_cnt++; if (g !== 4'b0010) $display("FAIL single_grant got %b want 0010", g); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL single_busy_rise got %b want 1", bus.busy); else pass_cnt++;
    bus.req = 4'b0000;
    wait_done(d, r, dc, sg);
    e = sb.pop_front();
    total_cnt++; if (dc !== 4) $display("FAIL single_latency got %0d want 4", dc); else pass_cnt++;
    total_cnt++; if (d !== e.oh) $display("FAIL single_done got %b want %b", d, e.oh); else pass_cnt++;
    total_cnt++; if (r !== e.res) $display("FAIL single_result got %0d want %0d", r, e.res); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL single_busy_at_done got %b want 1", bus.busy); else pass_cnt++;
    @(negedge clock);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_busy_fall got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 4'b0000) $display("FAIL single_done_pulse got %b want 0000", bus.done); else pass_cnt++;
    repeat (3) @(negedge clock);
    total_cnt++; if (bus.result !== 18'd243) $display("FAIL single_hold got %0d want 243", bus.result); else pass_cnt++;
  endtask

  task automatic test_boundary();
    logic [W-1:0] vals [3] = '{18'd0, 18'd1, 18'd20};
    logic [W-1:0] exps [3] = '{18'd0, 18'd1, 18'd54272};
    logic [NR-1:0] g, d;
    logic [W-1:0]  r;
    int gc, dc;
    bit sg;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      set_n(2, vals[k]);
      push_exp(2, exps[k]);
      @(negedge clock);
      bus.req = 4'b0100;
      wait_grant(g, gc);
      bus.req = 4'b0000;
      wait_done(d, r, dc, sg);
      e = sb.pop_front();
      total_cnt++; if ({d, r} !== {e.oh, e.res}) $display("FAIL boundary_n%0d got done=%b res=%0d want done=%b res=%0d", vals[k], d, r, e.oh, e.res); else pass_cnt++;
      set_n(2, 18'd7);
      repeat (4) @(negedge clock);
      total_cnt++; if (bus.result !== e.res) $display("FAIL boundary_hold_n%0d got %0d want %0d", vals[k], bus.result, e.res); else pass_cnt++;
    end
  endtask

  task automatic test_all_clients();
    logic [NR-1:0] g, d;
    logic [W-1:0]  r;
    int gc, dc, prev_dc;
    bit sg;
    exp_t e;
    do_reset();
    set_n(0, 18'd1); set_n(1, 18'd2); set_n(2, 18'd3); set_n(3, 18'd4);
    push_exp(0, 18'd1); push_exp(1, 18'd32); push_exp(2, 18'd243); push_exp(3, 18'd1024);
    bus.req = 4'b1111;
    prev_dc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, gc);
      total_cnt++; if (g !== (4'b0001 << k)) $display("FAIL all_grant%0d got %b want %b", k, g, 4'b0001 << k); else pass_cnt++;
      if (k > 0) begin
        total_cnt++; if (prev_dc + gc !== 6) $display("FAIL all_spacing%0d got %0d want 6", k, prev_dc + gc); else pass_cnt++;
      end
      bus.req[k] = 1'b0;
      wait_done(d, r, dc, sg);
      prev_dc = dc;
      e = sb.pop_front();
      total_cnt++; if ({d, r} !== {e.oh, e.res}) $display("FAIL all_done%0d got done=%b res=%0d want done=%b res=%0d", k, d, r, e.oh, e.res); else pass_cnt++;
      total_cnt++; if (sg !== 1'b0) $display("FAIL all_overlap%0d got grant_seen=%b want 0", k, sg); else pass_cnt++;
    end
  endtask

  task automatic test_fairness();
    logic [NR-1:0] g, d, want;
    logic [W-1:0]  r;
    int gc, dc;
    bit sg;
    exp_t e;
    do_reset();
    set_n(0, 18'd2); set_n(2, 18'd3);
    push_exp(0, 18'd32); push_exp(2, 18'd243); push_exp(0, 18'd32); push_exp(2, 18'd243);
    bus.req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 1) ? 4'b0100 : 4'b0001;
      wait_grant(g, gc);
      total_cnt++; if (g !== want) $display("FAIL fair_grant%0d got %b want %b", k, g, want); else pass_cnt++;
      if (k == 3) bus.req = 4'b0000;
      wait_done(d, r, dc, sg);
      e = sb.pop_front();
      total_cnt++; if ({d, r} !== {e.oh, e.res}) $display("FAIL fair_done%0d got done=%b res=%0d want done=%b res=%0d", k, d, r, e.oh, e.res); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] g, d;
    logic [W-1:0]  r;
    int gc, dc, ndone;
    bit sg;
    exp_t e;
    set_n(1, 18'd5);
    @(negedge clock);
    bus.req = 4'b0010;
    wait_grant(g, gc);
    total_cnt++; if (g !== 4'b0010) $display("FAIL rmid_grant got %b want 0010", g); else pass_cnt++;
    bus.req = 4'b0000;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.grant !== 4'b0000) $display("FAIL rmid_grant_clr got %b want 0000", bus.grant); else pass_cnt++;
    total_cnt++; if (bus.done !== 4'b0000) $display("FAIL rmid_done_clr got %b want 0000", bus.done); else pass_cnt++;
    total_cnt++; if (bus.result !== 18'd0) $display("FAIL rmid_result got %0d want 0", bus.result); else pass_cnt++;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus.done != 4'b0000) ndone++;
    end
    total_cnt++; if (ndone !== 0) $display("FAIL rmid_no_done got %0d want 0", ndone); else pass_cnt++;
    sb.delete();
    set_n(0, 18'd3); set_n(2, 18'd2);
    push_exp(0, 18'd243);
    bus.req = 4'b0101;
    wait_grant(g, gc);
    total_cnt++; if (g !== 4'b0001) $display("FAIL rmid_priority got %b want 0001", g); else pass_cnt++;
    bus.req = 4'b0000;
    wait_done(d, r, dc, sg);
    e = sb.pop_front();
    total_cnt++; if ({d, r} !== {e.oh, e.res}) $display("FAIL rmid_done got done=%b res=%0d want done=%b res=%0d", d, r, e.oh, e.res); else pass_cnt++;
  endtask

  task automatic test_ignored();
    logic [NR-1:0] g, d;
    logic [W-1:0]  r;
    int gc, dc, ngrant;
    bit sg;
    exp_t e;
    repeat (2) @(negedge clock);
    set_n(3, 18'd3);
    push_exp(3, 18'd243);
    bus.req = 4'b1000;
    wait_grant(g, gc);
    total_cnt++; if (g !== 4'b1000) $display("FAIL ign_grant got %b want 1000", g); else pass_cnt++;
    bus.req = 4'b0000;
    @(negedge clock);
    set_n(3, 18'd7);
    bus.req = 4'b0011;
    @(negedge clock);
    set_n(3, 18'd9);
    bus.req = 4'b0001;
    wait_done(d, r, dc, sg);
    bus.req = 4'b0000;
    e = sb.pop_front();
    total_cnt++; if ({d, r} !== {e.oh, e.res}) $display("FAIL ign_done got done=%b res=%0d want done=%b res=%0d", d, r, e.oh, e.res); else pass_cnt++;
    total_cnt++; if (sg !== 1'b0) $display("FAIL ign_early_grant got grant_seen=%b want 0", sg); else pass_cnt++;
    ngrant = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.grant != 4'b0000) ngrant++;
    end
    total_cnt++; if (ngrant !== 0) $display("FAIL ign_stray_grant got %0d want 0", ngrant); else pass_cnt++;
  endtask

  initial begin
    bus.req = 4'b0000;
    bus.n   = '0;
    test_reset();
    test_single();
    test_boundary();
    test_all_clients();
    test_fairness();
    test_reset_mid();
    test_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
